// File: rtl/fight_core.sv
// Match state for the fight game: both health bars, player attack cooldown and
// timed block, the CPU wind-up/strike schedule, and win/lose/draw detection.
module fight_core #(
    parameter int HEALTH_W   = 8,
    parameter int MAX_HEALTH = 100,
    parameter int P_DMG      = 5,
    parameter int CPU_DMG    = 10,
    parameter int COOLDOWN   = 50000000,
    parameter int BLOCK_LEN  = 30000000,
    parameter int CPU_PERIOD = 100000000,
    parameter int WINDUP     = 25000000,
    parameter int CNT_W      = 28
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          keyboard_input,
    input  logic                key_valid,
    output logic [HEALTH_W-1:0] p1_health_out,
    output logic [HEALTH_W-1:0] cpu_health_out,
    output logic                cpu_isAttacking,
    output logic                p1_blocking,
    output logic [1:0]          hit_pulse,
    output logic [1:0]          game_state,
    output logic [1:0]          winner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FIGHT = 2'd1;
    localparam logic [1:0] S_OVER  = 2'd2;

    localparam logic [3:0] KEY_ATK   = 4'd1;
    localparam logic [3:0] KEY_BLK   = 4'd2;
    localparam logic [3:0] KEY_START = 4'd3;

    localparam logic [HEALTH_W-1:0] H_MAX   = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] H_PDMG  = HEALTH_W'(P_DMG);
    localparam logic [HEALTH_W-1:0] H_CDMG  = HEALTH_W'(CPU_DMG);
    localparam logic [HEALTH_W-1:0] H_ZERO  = '0;

    localparam logic [CNT_W-1:0] CD_LOAD  = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] BLK_LOAD = CNT_W'(BLOCK_LEN - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(CPU_PERIOD - 1);
    localparam logic [CNT_W-1:0] WND_LAST = CNT_W'(WINDUP - 1);
    localparam logic [CNT_W-1:0] C_ZERO   = '0;
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cd_cnt;
    logic [CNT_W-1:0] blk_cnt;
    logic [CNT_W-1:0] cpu_cnt;

    logic                in_fight;
    logic                key_atk, key_blk, key_start;
    logic                atk_ok, blk_ok, strike, p1_hit;
    logic [HEALTH_W-1:0] cpu_next, p1_next;
    logic                cpu_dead, p1_dead;

    assign in_fight  = (game_state == S_FIGHT);
    assign key_atk   = key_valid && (keyboard_input == KEY_ATK);
    assign key_blk   = key_valid && (keyboard_input == KEY_BLK);
    assign key_start = key_valid && (keyboard_input == KEY_START);

    // A block only protects if it was already up before the strike cycle.
    assign atk_ok = in_fight && key_atk && (cd_cnt == C_ZERO) && !p1_blocking;
    assign blk_ok = in_fight && key_blk && !p1_blocking;
    assign strike = in_fight && cpu_isAttacking && (cpu_cnt == WND_LAST);
    assign p1_hit = strike && !p1_blocking;

    assign cpu_next = !atk_ok ? cpu_health_out :
                      (cpu_health_out > H_PDMG) ? cpu_health_out - H_PDMG : H_ZERO;
    assign p1_next  = !p1_hit ? p1_health_out :
                      (p1_health_out > H_CDMG) ? p1_health_out - H_CDMG : H_ZERO;
    assign cpu_dead = (cpu_next == H_ZERO);
    assign p1_dead  = (p1_next == H_ZERO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            game_state      <= S_IDLE;
            winner          <= 2'd0;
            p1_health_out   <= H_MAX;
            cpu_health_out  <= H_MAX;
            cpu_isAttacking <= 1'b0;
            p1_blocking     <= 1'b0;
            hit_pulse       <= 2'b00;
            cd_cnt          <= C_ZERO;
            blk_cnt         <= C_ZERO;
            cpu_cnt         <= C_ZERO;
        end else begin
            hit_pulse <= {p1_hit, atk_ok};
            case (game_state)
                S_IDLE: begin
                    p1_health_out  <= H_MAX;
                    cpu_health_out <= H_MAX;
                    if (key_start) begin
                        game_state      <= S_FIGHT;
                        cpu_isAttacking <= 1'b0;
                        p1_blocking     <= 1'b0;
                        cd_cnt          <= C_ZERO;
                        blk_cnt         <= C_ZERO;
                        cpu_cnt         <= C_ZERO;
                    end
                end
                S_FIGHT: begin
                    p1_health_out  <= p1_next;
                    cpu_health_out <= cpu_next;

                    if (atk_ok)
                        cd_cnt <= CD_LOAD;
                    else if (cd_cnt != C_ZERO)
                        cd_cnt <= cd_cnt - C_ONE;

                    if (blk_ok) begin
                        p1_blocking <= 1'b1;
                        blk_cnt     <= BLK_LOAD;
                    end else if (p1_blocking) begin
                        if (blk_cnt == C_ZERO)
                            p1_blocking <= 1'b0;
                        else
                            blk_cnt <= blk_cnt - C_ONE;
                    end

                    // cpu_isAttacking doubles as the WAIT/WIND phase bit.
                    if (!cpu_isAttacking) begin
                        if (cpu_cnt == PER_LAST) begin
                            cpu_isAttacking <= 1'b1;
                            cpu_cnt         <= C_ZERO;
                        end else begin
                            cpu_cnt <= cpu_cnt + C_ONE;
                        end
                    end else begin
                        if (cpu_cnt == WND_LAST) begin
                            cpu_isAttacking <= 1'b0;
                            cpu_cnt         <= C_ZERO;
                        end else begin
                            cpu_cnt <= cpu_cnt + C_ONE;
                        end
                    end

                    // Last assignment wins: entering OVER freezes everything.
                    if (cpu_dead || p1_dead) begin
                        game_state      <= S_OVER;
                        winner          <= {p1_dead, cpu_dead};
                        cpu_isAttacking <= 1'b0;
                        p1_blocking     <= 1'b0;
                        cd_cnt          <= C_ZERO;
                        blk_cnt         <= C_ZERO;
                        cpu_cnt         <= C_ZERO;
                    end
                end
                S_OVER: begin
                    cpu_isAttacking <= 1'b0;
                    p1_blocking     <= 1'b0;
                    if (key_start) begin
                        game_state     <= S_FIGHT;
                        winner         <= 2'd0;
                        p1_health_out  <= H_MAX;
                        cpu_health_out <= H_MAX;
                        cd_cnt         <= C_ZERO;
                        blk_cnt        <= C_ZERO;
                        cpu_cnt        <= C_ZERO;
                    end
                end
                default: begin
                    game_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fight_core.sv
// Bench for fight_core: directed match scenarios plus random key traffic, all
// checked every cycle against a cycle-number based model of the match rules.
module tb_fight_core;

    localparam int HW   = 8;
    localparam int MAXH = 20;
    localparam int PD   = 5;
    localparam int CDMG = 10;
    localparam int COOL = 4;
    localparam int BLEN = 6;
    localparam int PER  = 16;
    localparam int WU   = 4;
    localparam int CW   = 28;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    keyboard_input = 4'd0;
    logic          key_valid = 1'b0;
    logic [HW-1:0] p1_health_out, cpu_health_out;
    logic          cpu_isAttacking, p1_blocking;
    logic [1:0]    hit_pulse, game_state, winner;

    fight_core #(
        .HEALTH_W(HW), .MAX_HEALTH(MAXH), .P_DMG(PD), .CPU_DMG(CDMG),
        .COOLDOWN(COOL), .BLOCK_LEN(BLEN), .CPU_PERIOD(PER), .WINDUP(WU), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .keyboard_input(keyboard_input), .key_valid(key_valid),
        .p1_health_out(p1_health_out), .cpu_health_out(cpu_health_out),
        .cpu_isAttacking(cpu_isAttacking), .p1_blocking(p1_blocking),
        .hit_pulse(hit_pulse), .game_state(game_state), .winner(winner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: timers are absolute cycle numbers, CPU schedule is a fixed period.
    int cyc = 0;
    int m_state, m_p1, m_cpu, m_win, m_hit;
    int fs;          // cycle number of the first FIGHT cycle
    int cd_ready;    // first cycle an attack may be accepted
    int blk_s, blk_e;

    function automatic int sat(int h, int d);
        return (h > d) ? h - d : 0;
    endfunction

    function automatic int phase(int c);
        return (c - fs) % (PER + WU);
    endfunction

    function automatic int m_blocking(int c);
        return (m_state == 1 && c >= blk_s && c <= blk_e) ? 1 : 0;
    endfunction

    function automatic int m_attacking(int c);
        return (m_state == 1 && phase(c) >= PER) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("p1_health", 32'(p1_health_out), m_p1);
        chk("cpu_health", 32'(cpu_health_out), m_cpu);
        chk("cpu_isAttacking", 32'(cpu_isAttacking), m_attacking(cyc));
        chk("p1_blocking", 32'(p1_blocking), m_blocking(cyc));
        chk("hit_pulse", 32'(hit_pulse), m_hit);
        chk("game_state", 32'(game_state), m_state);
        chk("winner", 32'(winner), m_win);
    endtask

    task automatic model_reset();
        m_state = 0; m_p1 = MAXH; m_cpu = MAXH; m_win = 0; m_hit = 0;
        fs = 0; cd_ready = 0; blk_s = 1; blk_e = 0;
    endtask

    task automatic model_start(input int c);
        m_state = 1; m_p1 = MAXH; m_cpu = MAXH; m_win = 0;
        fs = c + 1; cd_ready = c + 1; blk_s = 1; blk_e = 0;
    endtask

    // One clock cycle with the given key; called #1 after a rising edge.
    task automatic step(input bit v, input int code);
        int c, np1, ncpu, blk_now;
        bit strike;
        key_valid = v;
        keyboard_input = 4'(code);
        c = cyc;
        blk_now = m_blocking(c);
        strike = (m_state == 1) && (phase(c) == PER + WU - 1);
        m_hit = 0;
        case (m_state)
            0: if (v && code == 3) model_start(c);
            1: begin
                np1 = m_p1; ncpu = m_cpu;
                if (v && code == 1 && c >= cd_ready && blk_now == 0) begin
                    ncpu = sat(m_cpu, PD); m_hit += 1; cd_ready = c + COOL;
                end
                if (v && code == 2 && blk_now == 0) begin
                    blk_s = c + 1; blk_e = c + BLEN;
                end
                if (strike && blk_now == 0) begin
                    np1 = sat(m_p1, CDMG); m_hit += 2;
                end
                m_p1 = np1; m_cpu = ncpu;
                if (np1 == 0 || ncpu == 0) begin
                    m_state = 2;
                    m_win = (np1 == 0 && ncpu == 0) ? 3 : (ncpu == 0) ? 1 : 2;
                end
            end
            default: if (v && code == 3) model_start(c);
        endcase
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        keyboard_input = 4'd0;
        cyc++;
        check_outputs();
    endtask

    task automatic press(input int code);
        step(1'b1, code);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    // Idle until the next step is FIGHT cycle `target`.
    task automatic run_to(input int target);
        for (int i = 0; i < 200 && (cyc - fs) < target; i++) step(1'b0, 0);
        chk("run_to_reached", cyc - fs, target);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check_outputs();
        @(posedge clk);
        #1 reset = 1'b0;
        cyc++;
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();
        idle(2);
        press(1);                                  // attack ignored in IDLE
        chk("idle_cpu", 32'(cpu_health_out), MAXH);

        // Cooldown: second attack dropped, third accepted
        press(3);
        press(1);
        chk("t1_cpu15", 32'(cpu_health_out), 15);
        chk("t1_hit0", 32'(hit_pulse), 1);
        idle(1);
        press(1);
        chk("t1_drop", 32'(cpu_health_out), 15);
        idle(2);
        press(1);
        chk("t1_cpu10", 32'(cpu_health_out), 10);

        // Unopposed CPU strikes until the player loses
        run_to(16);
        chk("t2_windup", 32'(cpu_isAttacking), 1);
        run_to(19);
        step(1'b0, 0);
        chk("t2_p1_10", 32'(p1_health_out), 10);
        chk("t2_hit1", 32'(hit_pulse), 2);
        run_to(39);
        step(1'b0, 0);
        chk("t2_state", 32'(game_state), 2);
        chk("t2_winner", 32'(winner), 2);

        // OVER ignores attack/block, start restarts
        press(1);
        press(2);
        chk("t5_cpu_frozen", 32'(cpu_health_out), 10);
        chk("t5_no_block", 32'(p1_blocking), 0);
        press(3);
        chk("t5_state", 32'(game_state), 1);
        chk("t5_p1", 32'(p1_health_out), MAXH);
        chk("t5_winner", 32'(winner), 0);

        // Early block protects; block on strike cycle does not
        run_to(16);
        press(2);
        run_to(19);
        chk("t3_blocking", 32'(p1_blocking), 1);
        step(1'b0, 0);
        chk("t3_p1_safe", 32'(p1_health_out), MAXH);
        chk("t3_no_hit", 32'(hit_pulse), 0);
        run_to(39);
        press(2);
        chk("t3_late_block", 32'(p1_health_out), 10);

        // Simultaneous final blows -> draw
        run_to(46); press(1);
        run_to(50); press(1);
        run_to(54); press(1);
        chk("t4_cpu5", 32'(cpu_health_out), 5);
        run_to(59); press(1);
        chk("t4_hit_both", 32'(hit_pulse), 3);
        chk("t4_state", 32'(game_state), 2);
        chk("t4_winner", 32'(winner), 3);

        // Random key traffic
        press(3);
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 3) == 0, int'($urandom % 16));
        end

        // Reset during WIND with block held
        do_reset();
        press(3);
        run_to(16);
        press(2);
        run_to(19);
        chk("t6_wind", 32'(cpu_isAttacking), 1);
        chk("t6_block", 32'(p1_blocking), 1);
        #3 reset = 1'b1;
        #1 model_reset();
        check_outputs();
        @(posedge clk);
        #1 reset = 1'b0;
        cyc++;
        check_outputs();
        chk("t6_idle", 32'(game_state), 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
